// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with a MemReady wait/timeout handshake and a sticky fault halt.
// Optional ADDI support is compiled in when MIPS_CTRL_ADDI_EN is defined.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic [1:0] Fault
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;
`ifdef MIPS_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'h08;
`endif

    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t           state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_wait_cnt;
    logic [1:0]       fault_code, next_fault_code;
    logic             mem_state;
    logic             timeout;

    // Only the three memory-access states wait on MemReady; everywhere else it is ignored.
    assign mem_state = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);
    assign timeout   = mem_state && !MemReady && (wait_cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            fault_code <= '0;
        end else begin
            state      <= next_state;
            wait_cnt   <= next_wait_cnt;
            fault_code <= next_fault_code;
        end
    end

    always_comb begin
        next_state      = state;
        next_fault_code = fault_code;
        next_wait_cnt   = '0;
        if (mem_state && !MemReady && !timeout) begin
            next_wait_cnt = wait_cnt + CNT_W'(1);
        end
        if (timeout) begin
            next_state      = S_FAULT;
            next_fault_code = FAULT_TIMEOUT;
        end else begin
            case (state)
                S_FETCH:  if (MemReady) next_state = S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_R:         next_state = S_REXE;
                        OP_LW, OP_SW: next_state = S_MADDR;
                        OP_BEQ:       next_state = S_BEQ;
                        OP_J:         next_state = S_JMP;
`ifdef MIPS_CTRL_ADDI_EN
                        OP_ADDI:      next_state = S_IEXE;
`endif
                        default: begin
                            next_state      = S_FAULT;
                            next_fault_code = FAULT_ILLEGAL;
                        end
                    endcase
                end
                S_MADDR:  next_state = (Opcode == OP_SW) ? S_MWR : S_MRD;
                S_MRD:    if (MemReady) next_state = S_MWB;
                S_MWB:    next_state = S_FETCH;
                S_MWR:    if (MemReady) next_state = S_FETCH;
                S_REXE:   next_state = S_RWB;
                S_RWB:    next_state = S_FETCH;
                S_BEQ:    next_state = S_FETCH;
                S_JMP:    next_state = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
                S_IEXE:   next_state = S_IWB;
                S_IWB:    next_state = S_FETCH;
`endif
                S_FAULT:  next_state = S_FAULT;
                default: begin
                    next_state      = S_FAULT;
                    next_fault_code = FAULT_ILLEGAL;
                end
            endcase
        end
    end

    // Holding Rst_n low silences every enable immediately, so a reset mid-access never completes a write.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (Rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = MemReady;
                    IRWrite = MemReady;
                end
                S_DECODE: ALUSrcB = 2'b11;
                S_MADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_REXE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
`ifdef MIPS_CTRL_ADDI_EN
                S_IEXE: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_IWB: RegWrite = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign State = state;
    assign Fault = Rst_n ? fault_code : 2'b00;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench for mips_multicycle_ctrl: a sequencer predicts each cycle into a
// scoreboard queue and a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
        logic [1:0] f;
    } obs_t;

`ifdef MIPS_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MADDR = 2, ST_MRD = 3, ST_MWB = 4, ST_MWR = 5;
    localparam int ST_REXE = 6, ST_RWB = 7, ST_BEQ = 8, ST_JMP = 9, ST_IEXE = 10, ST_IWB = 11;
    localparam int ST_FAULT = 15;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource, Fault;
    logic [3:0] State;

    obs_t       got;
    obs_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [1:0] model_fault;

    mips_multicycle_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    assign got = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Fault};

    // Control word each state must present, straight from the state table.
    function automatic ctrl_t ctrlFor(input int st, input logic ready);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = ready; c.ir_write = ready; end
            ST_DECODE: c.alu_src_b = 2'b11;
            ST_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ST_MRD:    begin c.mem_read = 1; c.iord = 1; end
            ST_MWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
            ST_MWR:    begin c.mem_write = 1; c.iord = 1; end
            ST_REXE:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            ST_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
            ST_BEQ:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            ST_JMP:    begin c.pc_write = 1; c.pc_source = 2'b10; end
            ST_IEXE:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            ST_IWB:    c.reg_write = 1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int pickWait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return r % 4;
        if (r < 17) return 15;
        return 16;
    endfunction

    function automatic bit isLegal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) ||
               (ADDI_EN && op == OP_ADDI);
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue what the DUT must show for it.
    task automatic applyStimulus(input logic rst_n, input logic [5:0] op, input logic ready,
                                 input int exp_st, input logic [1:0] exp_f);
        obs_t e;
        @(posedge Clk);
        #1;
        Rst_n    = rst_n;
        Opcode   = op;
        MemReady = ready;
        e.st = 4'(exp_st);
        e.c  = rst_n ? ctrlFor(exp_st, ready) : ctrl_t'('0);
        e.f  = rst_n ? exp_f : 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input obs_t actual, input obs_t want, input string name);
        checks++;
        if (actual !== want) begin
            failures++;
            $display("[TB] FAIL %s: got state=%0d ctrl=%h fault=%b, want state=%0d ctrl=%h fault=%b",
                     name, actual.st, actual.c, actual.f, want.st, want.c, want.f);
        end
    endtask

    // A memory access: n not-ready cycles then one ready cycle, or a timeout once n reaches MAX_WAIT+1.
    task automatic memPhase(input int st, input logic [5:0] op, input int n, output bit ok);
        if (n >= 16) begin
            repeat (16) applyStimulus(1'b1, op, 1'b0, st, 2'b00);
            model_fault = 2'b10;
            ok = 1'b0;
        end else begin
            repeat (n) applyStimulus(1'b1, op, 1'b0, st, 2'b00);
            applyStimulus(1'b1, op, 1'b1, st, 2'b00);
            ok = 1'b1;
        end
    endtask

    task automatic faultTail();
        repeat (3) applyStimulus(1'b1, 6'($urandom), rnd(), ST_FAULT, model_fault);
        applyStimulus(1'b0, Opcode, rnd(), ST_FAULT, 2'b00);
        model_fault = 2'b00;
    endtask

    task automatic runInstr(input logic [5:0] op, input int fetch_wait, input int mem_wait,
                            input bit abort_mem);
        bit ok;
        int mst;
        memPhase(ST_FETCH, op, fetch_wait, ok);
        if (!ok) begin
            faultTail();
            return;
        end
        applyStimulus(1'b1, op, rnd(), ST_DECODE, 2'b00);
        case (op)
            OP_R: begin
                applyStimulus(1'b1, op, rnd(), ST_REXE, 2'b00);
                applyStimulus(1'b1, op, rnd(), ST_RWB, 2'b00);
            end
            OP_LW, OP_SW: begin
                applyStimulus(1'b1, op, rnd(), ST_MADDR, 2'b00);
                mst = (op == OP_LW) ? ST_MRD : ST_MWR;
                if (abort_mem) begin
                    applyStimulus(1'b0, op, rnd(), mst, 2'b00);
                    return;
                end
                memPhase(mst, op, mem_wait, ok);
                if (!ok) begin
                    faultTail();
                    return;
                end
                if (op == OP_LW) applyStimulus(1'b1, op, rnd(), ST_MWB, 2'b00);
            end
            OP_BEQ: applyStimulus(1'b1, op, rnd(), ST_BEQ, 2'b00);
            OP_J:   applyStimulus(1'b1, op, rnd(), ST_JMP, 2'b00);
            default: begin
                if (ADDI_EN && op == OP_ADDI) begin
                    applyStimulus(1'b1, op, rnd(), ST_IEXE, 2'b00);
                    applyStimulus(1'b1, op, rnd(), ST_IWB, 2'b00);
                end else begin
                    model_fault = 2'b01;
                    faultTail();
                end
            end
        endcase
    endtask

    initial begin
        obs_t want;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checkOutput(got, want, $sformatf("cycle_state%0d", want.st));
            end
        end
    end

    initial begin
        logic [5:0] op;
        int         sel;
        Rst_n       = 1'b0;
        Opcode      = OP_R;
        MemReady    = 1'b1;
        model_fault = 2'b00;
        @(posedge Clk);
        applyStimulus(1'b0, OP_R, 1'b1, ST_FETCH, 2'b00);

        runInstr(OP_R, 0, 0, 1'b0);
        runInstr(OP_LW, 0, 3, 1'b0);
        runInstr(OP_SW, 0, 16, 1'b0);
        runInstr(6'h3F, 0, 0, 1'b0);
        runInstr(OP_ADDI, 0, 0, 1'b0);
        runInstr(OP_BEQ, 1, 0, 1'b0);
        runInstr(OP_J, 15, 0, 1'b0);
        runInstr(OP_LW, 0, 15, 1'b0);
        runInstr(OP_SW, 0, 0, 1'b1);
        runInstr(OP_LW, 16, 0, 1'b0);
        runInstr(OP_R, 2, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    op = OP_R;
                2, 3:    op = OP_LW;
                4, 8:    op = OP_SW;
                5:       op = OP_BEQ;
                6:       op = OP_J;
                7:       op = OP_ADDI;
                default: begin
                    op = 6'($urandom);
                    while (isLegal(op)) op = 6'($urandom);
                end
            endcase
            runInstr(op, pickWait(), pickWait(), ($urandom_range(0, 19) == 0));
        end

        repeat (3) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d unchecked cycles, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
